div_unit: RTL
=============

# div_unit

Iterative 32-bit integer divide/remainder unit for the RV32M DIV, DIVU, REM and REMU instructions. It sits in the execute stage beside the single-cycle ALU and is selected when decode issues `ALU_DIV`. The divider is radix-2 restoring, one quotient bit per clock. While it runs it raises `busy` so the pipeline stalls, then returns one result with a single-cycle `done` pulse.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width. Only 32 is supported.

Ports:
- `clk`, input, 1: the unit's single clock; all state changes on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request a new operation. Accepted only when `busy`=0.
- `func3`, input, 3: operation select. 100=DIV, 101=DIVU, 110=REM, 111=REMU. Other codes are handled as DIVU.
- `dividend`, input, XLEN: rs1 value, sampled when `start` is accepted.
- `divisor`, input, XLEN: rs2 value, sampled when `start` is accepted.
- `flush`, input, 1: abort any in-flight operation (branch mispredict or halt).
- `busy`, output, 1: an operation is in flight; the pipeline must stall.
- `done`, output, 1: one-cycle pulse; `result` is valid in this cycle.
- `result`, output, XLEN: quotient or remainder. Holds its value until the next `done`.

## Operation
- **States:**
  - IDLE: `busy`=0.
  - RUN: 32 iterations, `busy`=1.
  - FINISH: `busy`=1, `done`=1, one cycle.
- **IDLE, `start` accepted:**
  - Latch `func3`.
  - For signed ops, latch the absolute values of both operands and record the sign of the quotient and of the remainder.
  - Check the special cases first:
    - Divisor 0: quotient = 0xFFFFFFFF, remainder = dividend (original signed value). Go straight to FINISH.
    - Signed overflow (DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF): quotient = 0x80000000, remainder = 0. Go straight to FINISH.
  - Otherwise clear the 33-bit partial remainder, set the iteration counter to 31 and go to RUN.
- **RUN, each cycle:**
  - Shift the partial remainder left one bit, bringing in the next dividend MSB.
  - Trial-subtract the divisor. If the difference is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
  - When the counter reaches 0, go to FINISH. Otherwise decrement the counter.
- **FINISH:**
  - Negate the quotient if the quotient sign is set (DIV only).
  - Negate the remainder if the dividend was negative (REM only).
  - Drive `result` with the quotient for DIV/DIVU or the remainder for REM/REMU.
  - Assert `done` and return to IDLE.
- **Width rules:**
  - Absolute value of 0x80000000 is 0x80000000, treated as unsigned.
  - The partial remainder is 33 bits so the trial subtraction carries the borrow.
  - All arithmetic is modulo 2^32.
- **`flush`:** in any state, the next state is IDLE with no `done`. `result` keeps its previous value. `flush` takes priority over `start` in the same cycle.
- **`start` while `busy`=1:** ignored, including during the FINISH cycle.
- **Reset:** in any state, including mid-RUN, the unit returns to IDLE. Reset values: `busy`=0, `done`=0, `result`=0, counter=0.

## Timing
- `start` is sampled at the edge that ends cycle 0.
- Normal operation:
  - Cycles 1–32: RUN.
  - Cycle 33: FINISH, `done`=1, `result` valid.
  - `busy`=1 in cycles 1–33.
  - Latency is 33 cycles from the accept edge to `done`.
- Special cases (divide by zero, signed overflow): FINISH in cycle 1, so `done` and a valid `result` appear one cycle after accept.
- Back-to-back operations:
  - The earliest next `start` accept is the cycle after FINISH, when `busy`=0.
  - Throughput is one operation per 34 cycles.
- `busy` and `done` are registered outputs, with no combinational path from `start`.
- `result` is registered and updates only on the edge that enters FINISH.

## Test plan
- After reset: `busy`=0, `done`=0, `result`=0.
- DIV 100/7: `result`=14 at cycle 33. REM 100/7: `result`=2. `busy` is high for exactly cycles 1–33.
- DIV of -7 (0xFFFFFFF9) by 2: `result`=0xFFFFFFFD. REM of the same: `result`=0xFFFFFFFF. DIVU 0xFFFFFFFF/2: `result`=0x7FFFFFFF. REMU 0xFFFFFFFF/2: `result`=1.
- Divide by zero:
  - DIV 5/0 gives 0xFFFFFFFF.
  - REM 5/0 gives 5.
  - REMU 0x80000000/0 gives 0x80000000.
  - Each has `done` in cycle 1.
- Signed overflow: DIV 0x80000000/0xFFFFFFFF gives 0x80000000 and REM gives 0, both with `done` in cycle 1. DIVU of the same operands gives 0 at cycle 33.
- Flush and reset mid-operation:
  - `flush` in cycle 10: `busy`=0 from cycle 11, no `done`, `result` unchanged.
  - `start` during RUN: ignored.
  - `rst` in cycle 20: unit idle from cycle 21.
  - A new DIV 9/3 issued afterwards returns 3 at its own cycle 33.

Source files
------------

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock.
// Latency: 33 cycles from the accept edge to done; divide-by-zero and signed overflow take 1 cycle.
// Backpressure: busy stalls the pipeline; start is ignored while busy, and flush aborts with no done.
//
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   start, func3      : launch request and operation select (100 DIV, 101 DIVU, 110 REM, 111 REMU)
//   dividend, divisor : rs1 / rs2 operands, sampled when start is accepted
//   flush             : abort any in-flight operation
//   busy, done        : registered status; done is a one-cycle pulse
//   result            : quotient or remainder, held until the next done
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      func3_q;
  logic            a_sgn;     // raw sign bit of the original dividend
  logic            b_sgn;     // raw sign bit of the original divisor
  logic [XLEN-1:0] divr;      // |divisor|
  logic [XLEN-1:0] quo;       // dividend bits shift out the top, quotient bits shift in the bottom
  logic [XLEN:0]   prem;      // 33-bit partial remainder

  // Decode of the incoming request (used only on the accept cycle).
  logic            in_signed;
  logic            in_rem;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            div0;
  logic            ovf;

  // Decode of the latched operation.
  logic            q_signed;
  logic            q_rem;
  logic            q_neg;
  logic            r_neg;

  // One restoring iteration.
  logic [XLEN:0]   prem_sh;
  logic [XLEN:0]   diff;
  logic            qbit;
  logic [XLEN:0]   prem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] fin_q;
  logic [XLEN-1:0] fin_r;
  logic [XLEN-1:0] fin_val;

  always_comb begin
    in_signed = func3[2] & ~func3[0];
    in_rem    = func3[2] & func3[1];
    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
    a_abs     = (in_signed && dividend[XLEN-1]) ? -dividend : dividend;
    b_abs     = (in_signed && divisor[XLEN-1])  ? -divisor  : divisor;
    div0      = (divisor == '0);
    ovf       = in_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
  end

  always_comb begin
    q_signed = func3_q[2] & ~func3_q[0];
    q_rem    = func3_q[2] & func3_q[1];
    q_neg    = q_signed & (a_sgn ^ b_sgn);
    r_neg    = q_signed & a_sgn;

    prem_sh  = {prem[XLEN-1:0], quo[XLEN-1]};
    // Bit XLEN of the difference is the borrow: set means the trial subtraction went negative.
    diff     = prem_sh - {1'b0, divr};
    qbit     = ~diff[XLEN];
    prem_nx  = qbit ? diff : prem_sh;
    quo_nx   = {quo[XLEN-2:0], qbit};

    fin_q    = q_neg ? -quo_nx : quo_nx;
    fin_r    = r_neg ? -prem_nx[XLEN-1:0] : prem_nx[XLEN-1:0];
    fin_val  = q_rem ? fin_r : fin_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      func3_q <= '0;
      a_sgn   <= 1'b0;
      b_sgn   <= 1'b0;
      divr    <= '0;
      quo     <= '0;
      prem    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else if (flush) begin
      // Abort wins over everything, including a same-cycle start; result is left untouched.
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            func3_q <= func3;
            a_sgn   <= dividend[XLEN-1];
            b_sgn   <= divisor[XLEN-1];
            divr    <= b_abs;
            quo     <= a_abs;
            prem    <= '0;
            cnt     <= CW'(XLEN - 1);
            busy    <= 1'b1;
            if (div0) begin
              // Remainder is the original (signed) dividend, not its magnitude.
              state  <= S_FINISH;
              done   <= 1'b1;
              result <= in_rem ? dividend : '1;
            end else if (ovf) begin
              state  <= S_FINISH;
              done   <= 1'b1;
              result <= in_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            end else begin
              state <= S_RUN;
            end
          end
        end

        S_RUN: begin
          prem <= prem_nx;
          quo  <= quo_nx;
          if (cnt == '0) begin
            // Sign fix-up is folded into the final iteration so result lands on the FINISH entry edge.
            state  <= S_FINISH;
            done   <= 1'b1;
            result <= fin_val;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_FINISH: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
